mul_hilo_ctrl: RTL and testbench

- Sequencer between the CPU decode/stall logic and the pipelined 32x32 unsigned multiplier core.
- Accepts MULT/MULTU requests and converts signed operands to magnitudes.
- Holds the core's start for its fixed latency, captures the 64-bit product and applies sign correction.
- Owns the architectural HI/LO registers, which also take MTHI/MTLO writes; busy drives the pipeline stall.

---
 rtl/mul_hilo_ctrl_pkg.sv | 16 +
 rtl/mul_hilo_ctrl_if.sv | 27 ++
 rtl/mul_sign_fix.sv | 13 +
 rtl/mul_hilo_ctrl.sv | 132 +++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared CPU constants for the HI/LO multiply sequencer and its multiplier core.
package mul_hilo_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int HILO_W     = 2 * XLEN;
    // Must match the multiplier core's cycle count; shared with the core instantiation.
    localparam int MUL_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        CLR  = 2'd3
    } mhc_state_e;

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// CPU-side request / HI-LO bus between decode/stall logic and the multiply sequencer.
interface mul_hilo_ctrl_if #(parameter int DW = 32);

    logic          req;
    logic          is_signed;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          flush;
    logic          hi_we;
    logic          lo_we;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output req, is_signed, op_a, op_b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  req, is_signed, op_a, op_b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negation: operand magnitude in, signed product out.
module mul_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // The most negative value maps to itself, which is its correct unsigned magnitude.
    assign res = neg ? ((~val) + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// MULT/MULTU sequencer: feeds magnitudes to the unsigned core, sign-fixes the product into HI/LO.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int DW      = XLEN,
    parameter int MUL_LAT = MUL_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    mul_hilo_ctrl_if.slave    cpu,
    output logic [DW-1:0]     mul_a,
    output logic [DW-1:0]     mul_b,
    output logic              mul_start,
    output logic              mul_rst,
    input  logic [2*DW-1:0]   mul_z
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    mhc_state_e          state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic                neg, neg_d;
    logic                done_q, done_d;
    logic [DW-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]       a_q, a_d, b_q, b_d;
    logic [2*DW-1:0]     prod, prod_d, prod_fix;
    logic [1:0][DW-1:0]  op_raw, op_mag;
    logic [1:0]          op_neg;

    assign op_raw = {cpu.op_b, cpu.op_a};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_op
            assign op_neg[i] = cpu.is_signed & op_raw[i][DW-1];
            mul_sign_fix #(.W(DW)) u_mag (
                .val (op_raw[i]),
                .neg (op_neg[i]),
                .res (op_mag[i])
            );
        end
    endgenerate

    mul_sign_fix #(.W(2*DW)) u_fix (
        .val (prod),
        .neg (neg),
        .res (prod_fix)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        neg_d   = neg;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod;
        case (state)
            IDLE: begin
                if (cpu.hi_we) hi_d = cpu.wdata;
                if (cpu.lo_we) lo_d = cpu.wdata;
                if (cpu.req && !cpu.flush) begin
                    a_d     = op_mag[0];
                    b_d     = op_mag[1];
                    neg_d   = op_neg[0] ^ op_neg[1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // cnt holds on the capture edge so it never wraps inside RUN
                if (cpu.flush) begin
                    state_d = CLR;
                end else if (cnt == CNT_LAST) begin
                    prod_d  = mul_z;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            FIX: begin
                if (cpu.flush) begin
                    state_d = CLR;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
            end
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Falling edge: shares the multiplier core's clock edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            neg    <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod   <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            neg    <= neg_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod   <= prod_d;
        end
    end

    assign cpu.busy  = (state != IDLE);
    assign cpu.done  = done_q;
    assign cpu.hi    = hi_q;
    assign cpu.lo    = lo_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_start = (state == RUN);
    // CLR realigns the core's internal cycle counter after an aborted multiply.
    assign mul_rst   = reset | (state == CLR);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Randomised self-checking bench for mul_hilo_ctrl with a behavioural multiplier core.
module tb_mul_hilo_ctrl;
    import mul_hilo_ctrl_pkg::*;

    localparam int DW  = XLEN;
    localparam int LAT = MUL_CYCLES;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   mul_a, mul_b;
    logic            mul_start, mul_rst;
    logic [2*DW-1:0] mul_z;
    int              errors = 0;
    int              checks = 0;
    int              kc;

    mul_hilo_ctrl_if #(.DW(DW)) cpu ();

    mul_hilo_ctrl #(.DW(DW), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_rst   (mul_rst),
        .mul_z     (mul_z)
    );

    always #5 clk = ~clk;

    // Core model: product appears only after LAT start edges; otherwise garbage.
    always @(negedge clk) begin
        if (mul_rst) begin
            kc    <= 0;
            mul_z <= '0;
        end else if (mul_start) begin
            kc    <= (kc == LAT-1) ? 0 : kc + 1;
            mul_z <= (kc == LAT-2) ? ({32'b0, mul_a} * {32'b0, mul_b}) : {$urandom, $urandom};
        end
    end

    function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) return 64'(sa * sb);
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input bit s, input logic [31:0] v);
        longint sv;
        sv = longint'($signed(v));
        if (s && sv < 0) return 32'(-sv);
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        cpu.req = 0; cpu.is_signed = 0; cpu.op_a = '0; cpu.op_b = '0;
        cpu.flush = 0; cpu.hi_we = 0; cpu.lo_we = 0; cpu.wdata = '0;
    endtask

    // Issues one request and observes the following LAT+4 edges.
    task automatic do_mul(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int start_n, output int done_n,
                          output int done_at, output logic [31:0] ma, output logic [31:0] mb);
        cpu.req = 1; cpu.is_signed = s; cpu.op_a = a; cpu.op_b = b;
        busy_n = 0; start_n = 0; done_n = 0; done_at = -1; ma = '0; mb = '0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (i == 0) begin
                cpu.req = 0;
                ma = mul_a;
                mb = mul_b;
            end
            if (cpu.busy)  busy_n++;
            if (mul_start) start_n++;
            if (cpu.done) begin done_n++; done_at = i; end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst got %b want 1", mul_rst); end
        checks++; if (cpu.busy !== 1'b0 || cpu.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b/%b want 0/0", cpu.busy, cpu.done); end
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", cpu.hi, cpu.lo); end
        checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0 || mul_start !== 1'b0) begin errors++; $display("FAIL reset_core got %h/%h/%b want 0/0/0", mul_a, mul_b, mul_start); end
        reset = 0;
        step();
        checks++; if (mul_rst !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", mul_rst); end
    endtask

    task automatic test_multu_max();
        int bn, sn, dn, da; logic [31:0] ma, mb;
        do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, sn, dn, da, ma, mb);
        checks++; if (bn !== LAT+1) begin errors++; $display("FAIL max_busy_cycles got %0d want %0d", bn, LAT+1); end
        checks++; if (sn !== LAT) begin errors++; $display("FAIL max_start_cycles got %0d want %0d", sn, LAT); end
        checks++; if (dn !== 1 || da !== LAT+1) begin errors++; $display("FAIL max_done got n=%0d at=%0d want n=1 at=%0d", dn, da, LAT+1); end
        checks++; if (cpu.hi !== 32'hFFFF_FFFE || cpu.lo !== 32'h0000_0001) begin errors++; $display("FAIL max_hilo got %h/%h want fffffffe/00000001", cpu.hi, cpu.lo); end
    endtask

    task automatic test_mult_signed();
        int bn, sn, dn, da; logic [31:0] ma, mb, a, b; bit s; logic [63:0] exp;
        do_mul(1, 32'hFFFF_FFFD, 32'd7, bn, sn, dn, da, ma, mb);
        checks++; if (cpu.hi !== 32'hFFFF_FFFF || cpu.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL neg3x7 got %h/%h want ffffffff/ffffffeb", cpu.hi, cpu.lo); end
        checks++; if (ma !== 32'd3 || mb !== 32'd7) begin errors++; $display("FAIL neg3x7_mag got %h/%h want 3/7", ma, mb); end
        do_mul(1, 32'h8000_0000, 32'h8000_0000, bn, sn, dn, da, ma, mb);
        checks++; if (cpu.hi !== 32'h4000_0000 || cpu.lo !== 32'h0) begin errors++; $display("FAIL minxmin got %h/%h want 40000000/0", cpu.hi, cpu.lo); end
        checks++; if (ma !== 32'h8000_0000) begin errors++; $display("FAIL minxmin_mag got %h want 80000000", ma); end
        do_mul(1, 32'h0, 32'hFFFF_FFF0, bn, sn, dn, da, ma, mb);
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h0) begin errors++; $display("FAIL zero_neg got %h/%h want 0/0", cpu.hi, cpu.lo); end
        for (int n = 0; n < 16; n++) begin
            s = 1'($urandom_range(0, 1));
            a = (n % 4 == 0) ? 32'h8000_0000 : $urandom;
            b = (n % 5 == 1) ? 32'hFFFF_FFFF : $urandom;
            exp = ref_prod(s, a, b);
            do_mul(s, a, b, bn, sn, dn, da, ma, mb);
            checks++; if ({cpu.hi, cpu.lo} !== exp) begin errors++; $display("FAIL rand_prod s=%0d a=%h b=%h got %h want %h", s, a, b, {cpu.hi, cpu.lo}, exp); end
            checks++; if (ma !== ref_mag(s, a) || mb !== ref_mag(s, b)) begin errors++; $display("FAIL rand_mag got %h/%h want %h/%h", ma, mb, ref_mag(s, a), ref_mag(s, b)); end
            checks++; if (dn !== 1 || da !== LAT+1) begin errors++; $display("FAIL rand_done got n=%0d at=%0d want n=1 at=%0d", dn, da, LAT+1); end
        end
    endtask

    task automatic test_flush();
        int bn, sn, dn, da; logic [31:0] ma, mb;
        cpu.hi_we = 1; cpu.wdata = 32'h1111_1111; step();
        cpu.hi_we = 0; cpu.lo_we = 1; cpu.wdata = 32'h2222_2222; step();
        cpu.lo_we = 0;
        checks++; if (cpu.hi !== 32'h1111_1111 || cpu.lo !== 32'h2222_2222) begin errors++; $display("FAIL mthi_mtlo got %h/%h want 11111111/22222222", cpu.hi, cpu.lo); end
        // flush while cnt == 4
        cpu.req = 1; cpu.is_signed = 1; cpu.op_a = 32'd5; cpu.op_b = 32'd6;
        step(); cpu.req = 0;
        for (int i = 0; i < 4; i++) step();
        cpu.flush = 1; step(); cpu.flush = 0;
        checks++; if (mul_rst !== 1'b1 || cpu.busy !== 1'b1 || mul_start !== 1'b0) begin errors++; $display("FAIL flush_clr got rst=%b busy=%b start=%b want 1/1/0", mul_rst, cpu.busy, mul_start); end
        step();
        checks++; if (mul_rst !== 1'b0 || cpu.busy !== 1'b0) begin errors++; $display("FAIL flush_idle got rst=%b busy=%b want 0/0", mul_rst, cpu.busy); end
        dn = 0;
        for (int i = 0; i < LAT + 2; i++) begin step(); if (cpu.done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", dn); end
        checks++; if (cpu.hi !== 32'h1111_1111 || cpu.lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_hilo got %h/%h want 11111111/22222222", cpu.hi, cpu.lo); end
        // flush on the FIX cycle
        cpu.req = 1; cpu.is_signed = 0; cpu.op_a = 32'd9; cpu.op_b = 32'd9;
        step(); cpu.req = 0;
        for (int i = 0; i < LAT; i++) step();
        cpu.flush = 1; step(); cpu.flush = 0;
        checks++; if (cpu.done !== 1'b0 || mul_rst !== 1'b1 || cpu.lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_fix got done=%b rst=%b lo=%h want 0/1/22222222", cpu.done, mul_rst, cpu.lo); end
        step();
        // flush in IDLE drops the same-edge request
        cpu.flush = 1; cpu.req = 1; step(); cpu.flush = 0; cpu.req = 0;
        checks++; if (cpu.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_req got busy=%b want 0", cpu.busy); end
        do_mul(0, 32'd5, 32'd6, bn, sn, dn, da, ma, mb);
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h1E || da !== LAT+1) begin errors++; $display("FAIL after_flush got %h/%h at=%0d want 0/1e at=%0d", cpu.hi, cpu.lo, da, LAT+1); end
    endtask

    task automatic test_back_to_back();
        int dn, d0, d1; logic [31:0] hi_mid;
        cpu.hi_we = 1; cpu.wdata = 32'h5555_AAAA; step(); cpu.hi_we = 0;
        cpu.req = 1; cpu.is_signed = 0; cpu.op_a = 32'd3; cpu.op_b = 32'd4;
        dn = 0; d0 = -1; d1 = -1; hi_mid = '0;
        for (int i = 0; i < 2*LAT + 6; i++) begin
            step();
            if (cpu.done) begin dn++; if (d0 < 0) d0 = i; else d1 = i; end
            if (i == 3) begin cpu.hi_we = 1; cpu.wdata = 32'hABCD_0000; end
            if (i == 4) begin cpu.hi_we = 0; hi_mid = cpu.hi; end
            if (i == 2*LAT + 3) cpu.req = 0;
        end
        checks++; if (hi_mid !== 32'h5555_AAAA) begin errors++; $display("FAIL b2b_hi_we_busy got %h want 5555aaaa", hi_mid); end
        checks++; if (dn !== 2 || d0 !== LAT+1 || d1 !== 2*LAT+3) begin errors++; $display("FAIL b2b_done got n=%0d at %0d,%0d want 2 at %0d,%0d", dn, d0, d1, LAT+1, 2*LAT+3); end
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h0C) begin errors++; $display("FAIL b2b_hilo got %h/%h want 0/0c", cpu.hi, cpu.lo); end
    endtask

    task automatic test_same_edge_write();
        cpu.lo_we = 1; cpu.wdata = 32'hDEAD_BEEF; cpu.req = 1; cpu.is_signed = 0; cpu.op_a = 32'd2; cpu.op_b = 32'd2;
        step(); cpu.lo_we = 0; cpu.req = 0;
        checks++; if (cpu.lo !== 32'hDEAD_BEEF || cpu.busy !== 1'b1) begin errors++; $display("FAIL same_edge_lo got %h busy=%b want deadbeef busy=1", cpu.lo, cpu.busy); end
        for (int i = 0; i < LAT + 1; i++) step();
        checks++; if (cpu.done !== 1'b1 || cpu.lo !== 32'd4 || cpu.hi !== 32'h0) begin errors++; $display("FAIL same_edge_prod got done=%b %h/%h want 1 0/4", cpu.done, cpu.hi, cpu.lo); end
    endtask

    task automatic test_reset_mid();
        int bn, sn, dn, da; logic [31:0] ma, mb;
        cpu.hi_we = 1; cpu.lo_we = 1; cpu.wdata = 32'h0000_1234; step(); cpu.hi_we = 0; cpu.lo_we = 0;
        cpu.req = 1; cpu.is_signed = 1; cpu.op_a = 32'hFFFF_FFF9; cpu.op_b = 32'd9;
        step(); cpu.req = 0;
        for (int i = 0; i < 3; i++) step();
        reset = 1; step();
        checks++; if (cpu.busy !== 1'b0 || cpu.done !== 1'b0 || mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mid_ctl got busy=%b done=%b rst=%b want 0/0/1", cpu.busy, cpu.done, mul_rst); end
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h0) begin errors++; $display("FAIL reset_mid_hilo got %h/%h want 0/0", cpu.hi, cpu.lo); end
        reset = 0;
        dn = 0;
        for (int i = 0; i < LAT + 2; i++) begin step(); if (cpu.done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d want 0", dn); end
        do_mul(0, 32'd7, 32'd9, bn, sn, dn, da, ma, mb);
        checks++; if (cpu.hi !== 32'h0 || cpu.lo !== 32'h3F || dn !== 1) begin errors++; $display("FAIL after_reset got %h/%h n=%0d want 0/3f n=1", cpu.hi, cpu.lo, dn); end
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_flush();
        test_back_to_back();
        test_same_edge_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
